// File: rtl/fetch_instr_stage.sv
// Instruction-fetch stage: owns the PC, reads a word-addressed instruction memory
// with one cycle of latency, and supports stall, redirect-with-squash and program load.
module fetch_instr_stage #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_target,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [31:0]           pc_out,
  output logic [31:0]           pc_plus4_out,
  output logic                  instr_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           pc_plus4_q, pc_plus4_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  unused_target_bits;

  // PC bits [1:0] and everything above the index field alias away.
  assign rd_idx             = fetch_pc_q[ADDR_WIDTH+1:2];
  assign unused_target_bits = ^redirect_target[1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (redirect) begin
      // Squash the in-flight fetch; pc_out keeps describing the last live word.
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      instr_d    = '0;
      valid_d    = 1'b0;
    end else if (!stall) begin
      instr_d    = mem[rd_idx];
      pc_d       = fetch_pc_q;
      pc_plus4_d = fetch_pc_q + 32'd4;
      valid_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  // Loads proceed regardless of reset; a same-edge read sees the old word.
  always_ff @(posedge CLK) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_plus4_q;
  assign instr_valid  = valid_q;

endmodule

// File: tb/tb_fetch_instr_stage.sv
// Directed bench for fetch_instr_stage with an in-bench behavioural model.
module tb_fetch_instr_stage;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_target = '0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic [DW-1:0] instr_out;
  logic [31:0]   pc_out;
  logic [31:0]   pc_plus4_out;
  logic          instr_valid;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [31:0]   m_fpc;
  logic [DW-1:0] m_instr;
  logic [31:0]   m_pc;
  logic [31:0]   m_pc4;
  logic          m_valid;

  fetch_instr_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .instr_out(instr_out), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .instr_valid(instr_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model update from the rules: memory read uses the word before any same-edge write.
  task automatic model_edge();
    logic [DW-1:0] rd;
    rd = m_mem[(m_fpc / 4) % DEPTH];
    if (RST) begin
      m_fpc = 32'h0; m_instr = '0; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (redirect) begin
      m_fpc = redirect_target & 32'hFFFF_FFFC; m_instr = '0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = rd; m_pc = m_fpc; m_pc4 = m_fpc + 4; m_valid = 1'b1;
      m_fpc = m_fpc + 4;
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
  endtask

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    RST = r; stall = s; redirect = rd; redirect_target = tgt;
    prog_we = we; prog_addr = wa; prog_data = wd;
    @(posedge CLK);
    model_edge();
    #1;
    chk("valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("instr", instr_out, m_instr);
    chk("pc", pc_out, m_pc);
    chk("pc4", pc_plus4_out, m_pc4);
  endtask

  task automatic adv();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, '0, '0);
  endtask

  logic [31:0] prog [5];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_fpc = '0; m_instr = '0; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    prog[0] = 32'h8C220004; prog[1] = 32'h00441820; prog[2] = 32'hAC230008;
    prog[3] = 32'h10600002; prog[4] = 32'h00631820;

    // Load program while reset is held
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, AW'(i), prog[i]);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr_out, 32'h0);

    adv();
    chk("first_instr", instr_out, 32'h8C220004);
    chk("first_pc", pc_out, 32'h0);
    chk("first_valid", {31'b0, instr_valid}, 32'h1);
    adv();
    chk("second_instr", instr_out, 32'h00441820);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0, '0);
    chk("stall_instr", instr_out, 32'h00441820);
    chk("stall_pc", pc_out, 32'h4);
    chk("stall_pc4", pc_plus4_out, 32'h8);
    adv();
    chk("after_stall_instr", instr_out, 32'hAC230008);
    chk("after_stall_pc", pc_out, 32'h8);

    // Redirect to unaligned target: low bits dropped, one bubble
    step(1'b0, 1'b0, 1'b1, 32'h00000011, 1'b0, '0, '0);
    chk("bubble_valid", {31'b0, instr_valid}, 32'h0);
    chk("bubble_instr", instr_out, 32'h0);
    chk("bubble_pc_hold", pc_out, 32'h8);
    adv();
    chk("redir_instr", instr_out, 32'h00631820);
    chk("redir_pc", pc_out, 32'h10);

    // Redirect beats stall
    step(1'b0, 1'b1, 1'b1, 32'h0, 1'b0, '0, '0);
    chk("rs_valid", {31'b0, instr_valid}, 32'h0);
    adv();
    chk("rs_instr", instr_out, 32'h8C220004);
    chk("rs_pc", pc_out, 32'h0);

    // Aliasing: 0x400 maps to index 0
    step(1'b0, 1'b0, 1'b1, 32'h00000400, 1'b0, '0, '0);
    adv();
    chk("alias_instr", instr_out, 32'h8C220004);
    chk("alias_pc", pc_out, 32'h400);
    adv();
    // Fetch of index 2 collides with a write to index 2
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, AW'(2), 32'hDEADBEEF);
    chk("collide_instr", instr_out, 32'hAC230008);
    chk("collide_pc", pc_out, 32'h408);
    step(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, '0, '0);
    adv();
    chk("new_word_instr", instr_out, 32'hDEADBEEF);

    // Reset in the middle of a stall
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, '0, '0);
    chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
    chk("midrst_instr", instr_out, 32'h0);
    adv();
    chk("midrst_refetch", instr_out, 32'h8C220004);
    chk("midrst_pc", pc_out, 32'h0);
    adv();
    chk("mem_kept", instr_out, 32'h00441820);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, '0, '0);
    adv();
    chk("wrap_pc", pc_out, 32'hFFFFFFFC);
    chk("wrap_pc4", pc_plus4_out, 32'h0);
    chk("wrap_instr_unloaded", instr_out, 32'h0);
    adv();
    chk("wrap_next_pc", pc_out, 32'h0);
    chk("wrap_next_instr", instr_out, 32'h8C220004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_instr_stage.md
Name: fetch_instr_stage

Overview:
Parametrised instruction-fetch stage with an integrated word-addressed instruction memory. It owns the PC register and performs a registered (1-cycle) memory read. It supports pipeline stall, branch/jump redirect with squash, and a program-load write port. It feeds the IF/ID boundary of the MIPS pipeline and supersedes the purely combinational instruction memory.

Parameters:
ADDR_WIDTH, 8, word-index bits; memory depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
stall  input  1  hold PC and output registers (hazard unit)
redirect  input  1  take redirect_target as next PC and squash the in-flight fetch
redirect_target  input  32  byte address of the branch/jump target
prog_we  input  1  program-load write enable
prog_addr  input  ADDR_WIDTH  program-load word index
prog_data  input  DATA_WIDTH  program-load data
instr_out  output  DATA_WIDTH  fetched instruction (registered)
pc_out  output  32  byte address of instr_out
pc_plus4_out  output  32  pc_out + 4, for link/branch computation
instr_valid  output  1  instr_out/pc_out hold a live fetch

Behaviour:
- Clocking: one clock, synchronous active-high reset. Every output is registered.
- Memory:
  - DEPTH x DATA_WIDTH array, zero-initialised at time 0. RST does not clear it.
  - Word index = pc[ADDR_WIDTH+1:2]. PC bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo DEPTH*4.
- Internal next-fetch PC register fetch_pc.
- Priority per rising edge: RST > redirect > stall > advance.
- RST:
  - fetch_pc <= RESET_PC; instr_valid <= 0; instr_out <= 0 (NOP); pc_out <= 0; pc_plus4_out <= 0.
  - A write asserted on prog_we in the same cycle is still performed.
- redirect (RST=0):
  - fetch_pc <= {redirect_target[31:2], 2'b00}.
  - instr_valid <= 0; instr_out <= 0. pc_out and pc_plus4_out hold.
  - Overrides stall in the same cycle.
- stall (RST=0, redirect=0): fetch_pc, instr_out, pc_out, pc_plus4_out and instr_valid all hold.
- Advance (RST=0, redirect=0, stall=0):
  - instr_out <= mem[fetch_pc index]; pc_out <= fetch_pc; pc_plus4_out <= fetch_pc + 4.
  - instr_valid <= 1; fetch_pc <= fetch_pc + 4.
- Latency:
  - First valid instruction (at RESET_PC) appears after the first advancing edge following RST deassertion.
  - After a redirect, the target instruction appears after the next advancing edge, so a redirect costs exactly one bubble cycle.
- PC arithmetic is 32-bit modulo. 32'hFFFFFFFC + 4 wraps to 0 with no flag.
- Program-load port:
  - When prog_we=1, mem[prog_addr] <= prog_data on the edge.
  - prog_we is independent of stall, redirect and RST.
  - Same-edge read/write collision to the same index: the read returns the OLD word (read-before-write).
- Reset mid-operation: any stalled or in-flight fetch is discarded; state is identical to reset from power-up, apart from memory contents.

Test Plan:
- Load via prog port: mem[0..4] = 8C220004, 00441820, AC230008, 10600002, 00631820. Pulse RST, then advance 5 cycles -> instr_out sequence 8C220004, 00441820, AC230008, 10600002, 00631820 with pc_out 0, 4, 8, C, 10 and instr_valid=1 from the first edge after reset.
- After instr_out=00441820 (pc_out=4), assert stall for 3 cycles -> outputs frozen at 00441820 / 4 / 8. Release -> next instr_out=AC230008, pc_out=8.
- Redirect: assert redirect with target 32'h00000011 while at pc_out=8 -> next cycle instr_valid=0, instr_out=0. Following cycle instr_out=00631820, pc_out=10 (low bits of the target dropped).
- redirect and stall asserted together, target 0 -> redirect wins: bubble, then instr_out=8C220004, pc_out=0.
- Aliasing and collision (ADDR_WIDTH=8):
  - Redirect to 32'h00000400 -> instr_out=8C220004 (index 0), pc_out=400.
  - On an edge that fetches index 2 while prog_we writes DEADBEEF to index 2 -> instr_out=AC230008. A later fetch of index 2 returns DEADBEEF.
- Assert RST for one cycle in the middle of a stall -> instr_valid=0 and instr_out=0 next cycle. The next advancing edge fetches RESET_PC; memory contents are unchanged.
